usr_shift_sequencer: RTL and testbench

//  Command-driven controller for the 4-bit universal shift register (hold/SHR/SHL/load on a 2-bit select).

---
 rtl/usr_pkg.sv | 36 +++
 rtl/usr_shift_counter.sv | 46 ++++
 rtl/usr_shift_sequencer.sv | 143 ++++++++++++++
 tb/tb_usr_shift_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register sequencer.
//   - command op encodings (cmd_op)
//   - register select codes (usr_select)
//   - FSM state enum
//   - helper mapping a shift/rotate op onto the select code it needs
package usr_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Rotate-right is a right shift whose serial-in is fed back from bit 0,
  // so it shares the SHR select code.
  function automatic logic [1:0] shift_select(input logic [1:0] op);
    logic [1:0] sel;
    sel = SEL_SHR;
    if (op == OP_SHL) begin
      sel = SEL_SHL;
    end
    return sel;
  endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Loadable down-counter that times the SHIFT phase of the sequencer.
// Ports:
//   clk, reset   clock and synchronous active-high reset (count -> 0)
//   load         load load_value this cycle (has priority over dec)
//   load_value   new count value
//   dec          decrement by one; saturates at zero
//   zero         count is 0
//   last         count is 1 (final shift cycle)
module usr_shift_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);
  assign last = (count_reg == ONE);

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven controller for a 4-bit universal shift register
// (select 00 hold, 01 SHR, 10 SHL, 11 load). Accepts one command at a time
// over valid/ready, drives select/serial-in/parallel-in for exactly the
// cycles the command needs, then pulses done for one cycle.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_op            00 LOAD, 01 SHR, 10 SHL, 11 ROTR
//   cmd_count         shift/rotate count (ignored for LOAD)
//   cmd_fill          serial bit shifted in for SHR/SHL
//   cmd_data          parallel word for LOAD
//   usr_data_out      register contents, fed back for ROTR
//   usr_select        register select code
//   usr_shift_right   register MSB serial-in
//   usr_shift_left    register LSB serial-in
//   usr_parallel_in   register parallel-in (latched command data)
//   busy              command in progress
//   done              one-cycle completion pulse
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] usr_data_out,
  output logic [1:0]       usr_select,
  output logic             usr_shift_right,
  output logic             usr_shift_left,
  output logic [WIDTH-1:0] usr_parallel_in,
  output logic             busy,
  output logic             done
);

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       op_reg;
  logic             fill_reg;
  logic [WIDTH-1:0] data_reg;

  logic accept;
  logic cnt_zero;
  logic cnt_last;

  // Only bit 0 of the register is needed (rotate feedback).
  logic unused_data_bits;
  assign unused_data_bits = ^usr_data_out[WIDTH-1:1];

  assign accept = cmd_valid && cmd_ready;

  usr_shift_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_value(cmd_count),
    .dec       (state_reg == SHIFT),
    .zero      (cnt_zero),
    .last      (cnt_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD) begin
            state_next = LOAD;
          end else if (cmd_count == '0) begin
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      LOAD:  state_next = DONE;
      // The counter still holds the remaining shift count for this cycle;
      // a value of 1 means this is the last shift. Zero is a safe exit.
      SHIFT: begin
        if (cnt_last || cnt_zero) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      fill_reg  <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= cmd_op;
        fill_reg <= cmd_fill;
        data_reg <= cmd_data;
      end
    end
  end

  always_comb begin
    usr_select = SEL_HOLD;
    case (state_reg)
      LOAD:    usr_select = SEL_LOAD;
      SHIFT:   usr_select = shift_select(op_reg);
      default: usr_select = SEL_HOLD;
    endcase
  end

  // Serial-in values are only consumed while the matching select is active,
  // so they are decoded from the latched op alone.
  always_comb begin
    usr_shift_right = 1'b0;
    usr_shift_left  = 1'b0;
    case (op_reg)
      OP_SHR:  usr_shift_right = fill_reg;
      OP_ROTR: usr_shift_right = usr_data_out[0];
      OP_SHL:  usr_shift_left  = fill_reg;
      default: begin
        usr_shift_right = 1'b0;
        usr_shift_left  = 1'b0;
      end
    endcase
  end

  assign usr_parallel_in = data_reg;
  assign cmd_ready       = (state_reg == IDLE);
  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == DONE);

endmodule

// File: tb/tb_usr_shift_sequencer.sv
module tb_usr_shift_sequencer;

  localparam logic [1:0] T_LOAD = 2'b00;
  localparam logic [1:0] T_SHR  = 2'b01;
  localparam logic [1:0] T_SHL  = 2'b10;
  localparam logic [1:0] T_ROTR = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_count = 3'd0;
  logic       cmd_fill = 1'b0;
  logic [3:0] cmd_data = 4'd0;
  logic [3:0] usr_reg = 4'd0;
  logic [1:0] usr_select;
  logic       usr_shift_right;
  logic       usr_shift_left;
  logic [3:0] usr_parallel_in;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_count      (cmd_count),
    .cmd_fill       (cmd_fill),
    .cmd_data       (cmd_data),
    .usr_data_out   (usr_reg),
    .usr_select     (usr_select),
    .usr_shift_right(usr_shift_right),
    .usr_shift_left (usr_shift_left),
    .usr_parallel_in(usr_parallel_in),
    .busy           (busy),
    .done           (done)
  );

  // The attached 4-bit universal shift register.
  always @(posedge clk) begin
    case (usr_select)
      2'b01:   usr_reg <= {usr_shift_right, usr_reg[3:1]};
      2'b10:   usr_reg <= {usr_reg[2:0], usr_shift_left};
      2'b11:   usr_reg <= usr_parallel_in;
      default: usr_reg <= usr_reg;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command is a timeline of cycles counted from accept.
  // Cycle 1..lat-1 drive the operation, cycle lat is the done cycle.
  int         m_phase = 0;
  int         m_lat = 1;
  logic [1:0] m_op = 2'b00;
  logic       m_fill = 1'b0;
  logic [3:0] m_data = 4'd0;
  logic [3:0] m_reg = 4'd0;

  function automatic int latency(input logic [1:0] op, input logic [2:0] cnt);
    if (op == T_LOAD) return 2;
    return int'(cnt) + 1;
  endfunction

  always @(posedge clk) begin
    // register effect of the cycle that is ending (also on a reset edge)
    if (m_phase != 0 && m_phase < m_lat) begin
      case (m_op)
        T_LOAD: m_reg <= m_data;
        T_SHR:  m_reg <= {m_fill, m_reg[3:1]};
        T_SHL:  m_reg <= {m_reg[2:0], m_fill};
        default: m_reg <= {m_reg[0], m_reg[3:1]};
      endcase
    end
    if (reset) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (cmd_valid) begin
        m_phase <= 1;
        m_lat   <= latency(cmd_op, cmd_count);
        m_op    <= cmd_op;
        m_fill  <= cmd_fill;
        m_data  <= cmd_data;
      end
    end else if (m_phase == m_lat) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic       active;
      logic [1:0] exp_sel;
      active  = (m_phase != 0) && (m_phase < m_lat);
      exp_sel = 2'b00;
      if (active) exp_sel = (m_op == T_LOAD) ? 2'b11 : (m_op == T_SHL) ? 2'b10 : 2'b01;
      check("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("done", 32'(done), 32'((m_phase != 0) && (m_phase == m_lat)));
      check("select", 32'(usr_select), 32'(exp_sel));
      check("register", 32'(usr_reg), 32'(m_reg));
      if (active && m_op == T_SHR)  check("sr_fill", 32'(usr_shift_right), 32'(m_fill));
      if (active && m_op == T_ROTR) check("sr_rot", 32'(usr_shift_right), 32'(m_reg[0]));
      if (active && m_op == T_SHL)  check("sl_fill", 32'(usr_shift_left), 32'(m_fill));
      if (active && m_op == T_LOAD) check("par_in", 32'(usr_parallel_in), 32'(m_data));
    end
  end

  // Issue one command; lat = cycles from accept edge to done high, -1 on timeout.
  task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic fill,
                      input logic [3:0] data, input bit hold, output int lat);
    int budget;
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_fill = fill; cmd_data = data;
    budget = 0;
    while (!cmd_ready && budget < 50) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat;
    int n;
    int seen;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    started = 1;
    @(negedge clk);
    check("reset_select", 32'(usr_select), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);

    // 1: LOAD 1011
    send(T_LOAD, 3'd0, 1'b0, 4'b1011, 0, lat);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_reg", 32'(usr_reg), 32'b1011);
    @(negedge clk);
    check("t1_ready_back", 32'(cmd_ready), 32'd1);

    // 2: SHR 2 fill 1
    send(T_SHR, 3'd2, 1'b1, 4'b0000, 0, lat);
    check("t2_latency", 32'(lat), 32'd3);
    check("t2_reg", 32'(usr_reg), 32'b1110);

    // 3: load 0001, SHL 3 fill 0, ROTR 4
    send(T_LOAD, 3'd0, 1'b0, 4'b0001, 0, lat);
    send(T_SHL, 3'd3, 1'b0, 4'b1111, 0, lat);
    check("t3_shl_reg", 32'(usr_reg), 32'b1000);
    send(T_ROTR, 3'd4, 1'b1, 4'b0101, 0, lat);
    check("t3_rotr_latency", 32'(lat), 32'd5);
    check("t3_rotr_reg", 32'(usr_reg), 32'b1000);

    // 4: load 1001, ROTR 1, SHR 0
    send(T_LOAD, 3'd0, 1'b0, 4'b1001, 0, lat);
    send(T_ROTR, 3'd1, 1'b0, 4'b0000, 0, lat);
    check("t4_rotr_reg", 32'(usr_reg), 32'b1100);
    send(T_SHR, 3'd0, 1'b1, 4'b0000, 0, lat);
    check("t4_cnt0_latency", 32'(lat), 32'd1);
    check("t4_cnt0_reg", 32'(usr_reg), 32'b1100);

    // 5: back-to-back with valid held; second command waits for idle
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = T_LOAD; cmd_data = 4'b0110; cmd_count = 3'd0; cmd_fill = 1'b0;
    @(posedge clk); #1;
    cmd_op = T_SHL; cmd_count = 3'd1; cmd_fill = 1'b1; cmd_data = 4'b0000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 20);
    check("t5_accept_gap", 32'(n), 32'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    check("t5_second_latency", 32'(n), 32'd2);
    check("t5_reg", 32'(usr_reg), 32'b1101);

    // 6: reset in cycle 2 of SHL 5
    send(T_LOAD, 3'd0, 1'b0, 4'b0001, 0, lat);
    @(negedge clk); #1;
    cmd_valid = 1'b1; cmd_op = T_SHL; cmd_count = 3'd5; cmd_fill = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_select", 32'(usr_select), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (6) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("t6_no_done", 32'(seen), 32'd0);
    check("t6_frozen_reg", 32'(usr_reg), 32'b0111);

    // Random phase: fields wiggle every cycle, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_count = 3'($urandom_range(0, 7));
      cmd_fill  = 1'($urandom_range(0, 1));
      cmd_data  = 4'($urandom_range(0, 15));
      reset     = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk); #1;
    reset = 1'b0;
    cmd_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
